// File: rtl/port_scan_arbiter_if.sv
// Handshake bundle between the scan arbiter and its four requesting ports.
// The master side drives requests and done; the slave side is the arbiter.
interface port_scan_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] port_sel;
  logic       busy;
  logic       timeout;
  logic       wrap;

  modport master (
    output req, done,
    input  grant, port_sel, busy, timeout, wrap
  );

  modport slave (
    input  req, done,
    output grant, port_sel, busy, timeout, wrap
  );
endinterface

// File: rtl/port_scan_arbiter.sv
// Round-robin scanning arbiter for four level-sensitive requesters, with a
// per-grant hold limit and a one-cycle release gap between grants.
//
// state   | meaning
// IDLE    | no requests pending, ptr held
// SCAN    | stepping ptr until req[ptr] is found
// GRANT   | port ptr owns the resource, hold_cnt counts cycles
// RELEASE | one-cycle gap, ptr already advanced past the last owner
module port_scan_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  port_scan_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic       hold_limit;
  logic       grant_exit;

  assign hold_limit   = (hold_cnt == HOLD_LAST);
  assign grant_exit   = bus.done || !bus.req[ptr] || hold_limit;
  assign bus.port_sel = ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      bus.grant   <= 4'b0000;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
      bus.wrap    <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      bus.wrap    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req != 4'b0000) state <= SCAN;
        end
        SCAN: begin
          if (bus.req == 4'b0000) begin
            state <= IDLE;
          end else if (bus.req[ptr]) begin
            state     <= GRANT;
            hold_cnt  <= 8'd0;
            bus.grant <= 4'b0001 << ptr;
            bus.busy  <= 1'b1;
          end else begin
            ptr      <= ptr + 2'd1;
            bus.wrap <= (ptr == 2'd3);
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
          if (grant_exit) begin
            state       <= RELEASE;
            bus.grant   <= 4'b0000;
            ptr         <= ptr + 2'd1;
            bus.wrap    <= (ptr == 2'd3);
            // done on the limit cycle counts as a normal completion
            bus.timeout <= hold_limit && !bus.done;
          end
        end
        RELEASE: begin
          bus.busy <= 1'b0;
          state    <= (bus.req != 4'b0000) ? SCAN : IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/port_scan_arbiter.md
PORT_SCAN_ARBITER -- requirements
Module: port_scan_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of GRANT cycles per grant (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits, meaning the per-port service requests; it is level-sensitive, and bit i belongs to port i.
REQ-005 The block SHALL have port done, input, 1 bit, meaning the granted port has finished; it is sampled only in GRANT.
REQ-006 The block SHALL have port grant, output, 4 bits, meaning a one-hot grant to port ptr, asserted only in GRANT.
REQ-007 The block SHALL have port port_sel, output, 2 bits, meaning the current scan pointer ptr.
REQ-008 The block SHALL have port busy, output, 1 bit, meaning the state is GRANT or RELEASE.
REQ-009 The block SHALL have port timeout, output, 1 bit, meaning a 1-cycle pulse in the RELEASE that follows a hold-limit expiry.
REQ-010 The block SHALL have port wrap, output, 1 bit, meaning a 1-cycle pulse on the cycle after ptr advances from 3 to 0.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN, GRANT and RELEASE; all outputs SHALL be registered or decoded from registered state only.
REQ-012 In IDLE: if req==0, the FSM SHALL stay in IDLE with ptr held; otherwise it SHALL go to SCAN next cycle.
REQ-013 In SCAN, on each cycle: if req[ptr]==1, the FSM SHALL go to GRANT with ptr unchanged; else ptr SHALL advance by 1 (mod 4) and the FSM stays in SCAN.
REQ-014 If req becomes 0 while in SCAN, the FSM SHALL return to IDLE with ptr held at its current value.
REQ-015 Worst-case SCAN-to-GRANT latency SHALL be 4 cycles; with req[ptr] set on IDLE exit it SHALL be 1 cycle.
REQ-016 On entry to GRANT, hold_cnt (8 bits) SHALL be cleared; it SHALL increment each GRANT cycle and saturate at MAX_HOLD.
REQ-017 GRANT SHALL exit to RELEASE on the first cycle in which any of these hold: done==1; req[ptr]==0; hold_cnt==MAX_HOLD-1.
REQ-018 If done==1 and the hold limit occur in the same cycle, the exit SHALL be treated as a normal completion, with no timeout pulse.
REQ-019 RELEASE SHALL last exactly 1 cycle, with grant=0 and ptr advanced by 1 (mod 4) for round-robin fairness.
REQ-020 After RELEASE the FSM SHALL go to SCAN if any req bit is set, else to IDLE.
REQ-021 Whenever ptr advances from 3 to 0 (in SCAN or RELEASE), wrap SHALL pulse for exactly 1 cycle.
REQ-022 grant SHALL never have more than one bit set, and no port SHALL receive two consecutive grants while another port is requesting.
REQ-023 done asserted outside GRANT SHALL be ignored.

Reset
REQ-024 On rst=1, the block SHALL immediately force state=IDLE, ptr=0, hold_cnt=0, grant=0000, port_sel=00, busy=0, timeout=0 and wrap=0, regardless of clk.
REQ-025 If rst is asserted during GRANT, grant SHALL drop asynchronously with no RELEASE cycle.
REQ-026 After rst deasserts, scanning SHALL restart from port 0.

Verification
REQ-027 Single requester: req=0100 from reset, done after 3 cycles -> SCAN visits ptr 0,1,2; grant=0100 for 3 cycles; RELEASE sets ptr=3; then IDLE.
REQ-028 All requesting: req=1111 held, done pulsed 2 cycles into each grant -> grants in order 0001,0010,0100,1000,0001; wrap pulses once after the port-3 release.
REQ-029 Timeout: req=0001 held, done never asserted, MAX_HOLD=15 -> grant=0001 for exactly 15 cycles; timeout pulses once in RELEASE; next grant 0001 after rescan.
REQ-030 Simultaneous events: done=1 on the same cycle hold_cnt reaches MAX_HOLD-1 -> RELEASE with timeout=0.
REQ-031 Request withdrawal: req[2] drops mid-GRANT on port 2 -> RELEASE next cycle, ptr=3; req going to 0000 during SCAN -> IDLE with ptr held.
REQ-032 Reset mid-grant: rst pulsed between clock edges during GRANT on port 1 -> grant=0000 and busy=0 immediately; the first grant after release goes to the lowest-index requesting port.
